// File: rtl/demux4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one producer side, four consumer channels.
// CNT0..CNT3 exist only when DEMUX4_CNT_EN is defined.
interface demux4_stream_if #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
);
    if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("demux4_stream_if: WIDTH and CNT_WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] I;
    logic [1:0]       S;
    logic             I_valid;
    logic             I_ready;

    logic [WIDTH-1:0] O0, O1, O2, O3;
    logic             O0_valid, O1_valid, O2_valid, O3_valid;
    logic             O0_ready, O1_ready, O2_ready, O3_ready;

`ifdef DEMUX4_CNT_EN
    logic [CNT_WIDTH-1:0] CNT0, CNT1, CNT2, CNT3;

    modport master (
        output I, S, I_valid, O0_ready, O1_ready, O2_ready, O3_ready,
        input  I_ready, O0, O1, O2, O3, O0_valid, O1_valid, O2_valid, O3_valid,
        input  CNT0, CNT1, CNT2, CNT3
    );

    modport slave (
        input  I, S, I_valid, O0_ready, O1_ready, O2_ready, O3_ready,
        output I_ready, O0, O1, O2, O3, O0_valid, O1_valid, O2_valid, O3_valid,
        output CNT0, CNT1, CNT2, CNT3
    );
`else
    modport master (
        output I, S, I_valid, O0_ready, O1_ready, O2_ready, O3_ready,
        input  I_ready, O0, O1, O2, O3, O0_valid, O1_valid, O2_valid, O3_valid
    );

    modport slave (
        input  I, S, I_valid, O0_ready, O1_ready, O2_ready, O3_ready,
        output I_ready, O0, O1, O2, O3, O0_valid, O1_valid, O2_valid, O3_valid
    );
`endif
endinterface

// File: rtl/demux4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry register per channel.
// Optional per-channel drain counters are built when DEMUX4_CNT_EN is defined.
module demux4_stream #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input logic             CLK,
    input logic             RESET,
    demux4_stream_if.slave  bus
);
    if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("demux4_stream: WIDTH and CNT_WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] dat_p0 [4];
    logic [3:0]       vld_p0;
    logic [3:0]       rdy;
    logic [3:0]       drn;
    logic             acc;

    assign rdy = {bus.O3_ready, bus.O2_ready, bus.O1_ready, bus.O0_ready};
    assign drn = vld_p0 & rdy;

    // Readiness looks only at the addressed channel, so a stalled channel never blocks the others.
    assign bus.I_ready = ~vld_p0[bus.S] | rdy[bus.S];
    assign acc         = bus.I_valid & bus.I_ready;

    // Stage p0: channel registers; a fill wins over a drain so a draining channel refills without a bubble.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_p0 <= '0;
            for (int k = 0; k < 4; k++) begin
                dat_p0[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc && (bus.S == 2'(k))) begin
                    dat_p0[k] <= bus.I;
                    vld_p0[k] <= 1'b1;
                end else if (drn[k]) begin
                    vld_p0[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.O0       = dat_p0[0];
    assign bus.O1       = dat_p0[1];
    assign bus.O2       = dat_p0[2];
    assign bus.O3       = dat_p0[3];
    assign bus.O0_valid = vld_p0[0];
    assign bus.O1_valid = vld_p0[1];
    assign bus.O2_valid = vld_p0[2];
    assign bus.O3_valid = vld_p0[3];

`ifdef DEMUX4_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_p1 [4];

    // Stage p1: completed-transfer counters, wrapping naturally at 2^CNT_WIDTH.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < 4; k++) begin
                cnt_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (drn[k]) begin
                    cnt_p1[k] <= cnt_p1[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.CNT0 = cnt_p1[0];
    assign bus.CNT1 = cnt_p1[1];
    assign bus.CNT2 = cnt_p1[2];
    assign bus.CNT3 = cnt_p1[3];
`endif
endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed vector table, hand sequences, and a
// randomized run against a per-channel queue model. Counter checks need DEMUX4_CNT_EN.
module tb_demux4_stream;
    localparam int W  = 8;
    localparam int CW = 4;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    demux4_stream_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    demux4_stream #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    typedef struct {
        logic         rst;
        logic         iv;
        logic [1:0]   s;
        logic [W-1:0] i;
        logic [3:0]   rdy;
        logic         chk_rdy;
        logic         e_rdy;
        logic [3:0]   e_vld;
        logic [1:0]   e_ch;
        logic [W-1:0] e_dat;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [3:0] ovld;
    assign ovld = {bus.O3_valid, bus.O2_valid, bus.O1_valid, bus.O0_valid};

    function automatic logic [W-1:0] odat(input int k);
        case (k)
            0:       return bus.O0;
            1:       return bus.O1;
            2:       return bus.O2;
            default: return bus.O3;
        endcase
    endfunction

`ifdef DEMUX4_CNT_EN
    function automatic logic [CW-1:0] ocnt(input int k);
        case (k)
            0:       return bus.CNT0;
            1:       return bus.CNT1;
            2:       return bus.CNT2;
            default: return bus.CNT3;
        endcase
    endfunction
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [1:0] s,
                         input logic [W-1:0] i, input logic [3:0] rdy);
        RESET        = rst;
        bus.I_valid  = iv;
        bus.S        = s;
        bus.I        = i;
        bus.O0_ready = rdy[0];
        bus.O1_ready = rdy[1];
        bus.O2_ready = rdy[2];
        bus.O3_ready = rdy[3];
    endtask

    task automatic add(input logic rst, input logic iv, input logic [1:0] s, input logic [W-1:0] i,
                       input logic [3:0] rdy, input logic chk_rdy, input logic e_rdy,
                       input logic [3:0] e_vld, input logic [1:0] e_ch, input logic [W-1:0] e_dat);
        vec_t v;
        v.rst = rst; v.iv = iv; v.s = s; v.i = i; v.rdy = rdy;
        v.chk_rdy = chk_rdy; v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_ch = e_ch; v.e_dat = e_dat;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: each channel is a queue of at most one word, plus the last word written.
    logic [W-1:0] mq   [4][$];
    logic [W-1:0] mlast[4];
    int           mcnt [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mlast[k] = '0;
            mcnt[k]  = 0;
        end
    endtask

    initial begin
        logic         iv, e_rdy;
        logic [1:0]   s;
        logic [W-1:0] din;
        logic [3:0]   rdy;

        drive(1'b1, 1'b1, 2'd0, 8'h55, 4'b0000);

        // Reset with a word offered, then release.
        add(1, 1, 0, 8'h55, 4'b0000, 0, 0, 4'b0000, 0, 8'h00);
        add(1, 1, 1, 8'h66, 4'b0000, 1, 1, 4'b0000, 1, 8'h00);
        add(0, 0, 0, 8'h00, 4'b1111, 1, 1, 4'b0000, 2, 8'h00);
        // Single route to channel 2, hold under stall, then drain.
        add(0, 1, 2, 8'hA5, 4'b0000, 1, 1, 4'b0100, 2, 8'hA5);
        for (int n = 0; n < 5; n++) add(0, 0, 0, 8'h00, 4'b0000, 1, 1, 4'b0100, 2, 8'hA5);
        add(0, 0, 0, 8'h00, 4'b0100, 1, 1, 4'b0000, 2, 8'hA5);
        // Stall isolation: channel 1 full and stalled, channel 3 still accepts.
        add(0, 1, 1, 8'h11, 4'b0000, 1, 1, 4'b0010, 1, 8'h11);
        add(0, 1, 1, 8'h22, 4'b0000, 1, 0, 4'b0010, 1, 8'h11);
        add(0, 1, 3, 8'h3C, 4'b0000, 1, 1, 4'b1010, 3, 8'h3C);
        add(0, 0, 0, 8'h00, 4'b0000, 1, 1, 4'b1010, 1, 8'h11);
        // Simultaneous drain and refill on channel 2.
        add(0, 1, 2, 8'h44, 4'b0000, 1, 1, 4'b1110, 2, 8'h44);
        add(0, 1, 2, 8'h77, 4'b0100, 1, 1, 4'b1110, 2, 8'h77);
        add(0, 1, 2, 8'h88, 4'b0000, 1, 0, 4'b1110, 2, 8'h77);
        add(0, 0, 0, 8'h00, 4'b1111, 1, 1, 4'b0000, 3, 8'h3C);

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].rst, tbl[n].iv, tbl[n].s, tbl[n].i, tbl[n].rdy);
            #1;
            if (tbl[n].chk_rdy) check($sformatf("vec%0d_I_ready", n), 32'(bus.I_ready), 32'(tbl[n].e_rdy));
            tick();
            check($sformatf("vec%0d_valid", n), 32'(ovld), 32'(tbl[n].e_vld));
            check($sformatf("vec%0d_O%0d", n, tbl[n].e_ch), 32'(odat(tbl[n].e_ch)), 32'(tbl[n].e_dat));
        end

        // Full-rate stream on channel 0.
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1, 2'd0, W'(k), 4'b0001);
            #1;
            check($sformatf("stream%0d_I_ready", k), 32'(bus.I_ready), 32'd1);
            tick();
            check($sformatf("stream%0d_O0", k), 32'(bus.O0), 32'(k));
            check($sformatf("stream%0d_O0_valid", k), 32'(bus.O0_valid), 32'd1);
        end

        // Reset discards a held word and overrides a simultaneous accept.
        drive(1'b1, 1'b1, 2'd0, 8'hEE, 4'b0000);
        tick();
        check("rst_override_valid", 32'(ovld), 32'd0);
        check("rst_override_O0", 32'(bus.O0), 32'd0);

`ifdef DEMUX4_CNT_EN
        for (int k = 0; k < 4; k++) check($sformatf("cnt_rst_CNT%0d", k), 32'(ocnt(k)), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            drive(1'b0, 1'b1, 2'd0, W'(k), 4'b0001);
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001);
        tick();
        check("cnt_wrap_CNT0", 32'(ocnt(0)), 32'd1);
        for (int k = 1; k < 4; k++) check($sformatf("cnt_wrap_CNT%0d", k), 32'(ocnt(k)), 32'd0);
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
        tick();
        for (int k = 0; k < 4; k++) check($sformatf("cnt_clr_CNT%0d", k), 32'(ocnt(k)), 32'd0);
`endif

        // Randomized traffic against the queue model.
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
        tick();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            iv  = ($urandom_range(0, 3) != 0);
            s   = 2'($urandom_range(0, 3));
            din = W'($urandom);
            for (int k = 0; k < 4; k++) rdy[k] = ($urandom_range(0, 2) != 0);
            drive(1'b0, iv, s, din, rdy);
            #1;
            e_rdy = (mq[s].size() == 0) || rdy[s];
            check($sformatf("rnd%0d_I_ready", c), 32'(bus.I_ready), 32'(e_rdy));
            tick();
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() != 0 && rdy[k]) begin
                    void'(mq[k].pop_front());
                    mcnt[k] = (mcnt[k] + 1) % (1 << CW);
                end
            end
            if (iv && e_rdy) begin
                mq[s].push_back(din);
                mlast[s] = din;
            end
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rnd%0d_O%0d_valid", c, k), 32'(ovld[k]), 32'(mq[k].size() != 0));
                check($sformatf("rnd%0d_O%0d", c, k), 32'(odat(k)), 32'(mlast[k]));
`ifdef DEMUX4_CNT_EN
                check($sformatf("rnd%0d_CNT%0d", c, k), 32'(ocnt(k)), 32'(mcnt[k]));
`endif
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
- 1-to-4 stream demultiplexer; the distribution counterpart of the 4:1 mux.
- Routes each accepted input word to one of four output channels, chosen by a 2-bit select sampled with the word.
- Each channel has a one-entry output register with valid/ready handshake.
- Used to fan a single producer out to four consumers that each apply independent backpressure.

Parameters:
- WIDTH, 1, data width of the input word and of each output channel.
- CNT_WIDTH, 8, width of each per-channel transfer counter; used only when DEMUX4_CNT_EN is defined.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- I  input  WIDTH  input data word.
- S  input  2  destination channel for I (0..3); sampled only on the accept cycle.
- I_valid  input  1  producer has a word on I/S.
- I_ready  output  1  block accepts I/S this cycle.
- O0, O1, O2, O3  output  WIDTH  channel data registers.
- O0_valid, O1_valid, O2_valid, O3_valid  output  1  channel register holds a word.
- O0_ready, O1_ready, O2_ready, O3_ready  input  1  consumer takes the word this cycle.
- CNT0, CNT1, CNT2, CNT3  output  CNT_WIDTH  per-channel completed-transfer count; present only with DEMUX4_CNT_EN.

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge):
  - all Ok_valid=0 and all Ok=0.
  - Reset overrides any transfer in the same cycle; a word held mid-operation is discarded.
- Accept: acc = I_valid & I_ready. I_ready is combinational: I_ready = ~Ok_valid[S] | Ok_ready[S].
  - I_ready depends only on the addressed channel. A full, stalled channel blocks only words addressed to it; there is no reordering and no lookahead past a blocked word.
- Drain of channel k: drn_k = Ok_valid & Ok_ready.
- Next state of channel k, in priority order:
  - acc and S==k: Ok <= I, Ok_valid <= 1. This covers a simultaneous drain: the register is refilled, and back-to-back throughput is 1 word/cycle per channel.
  - else drn_k: Ok_valid <= 0, Ok holds its value.
  - else: hold.
- Latency: a word accepted at edge n appears on Ok/Ok_valid after edge n (1 cycle). No combinational path from I to Ok.
- Channel independence: channels not addressed by S are unaffected by acc. Up to 4 drains plus 1 fill can occur in the same cycle.
- I_valid=0: I and S are don't-care, no state changes except drains.
- S stable requirement: S must be held with I while I_valid=1 and I_ready=0 (standard valid/ready rule). An S change while stalled is legal; the block re-evaluates I_ready against the new S.
- Ok_ready while Ok_valid=0 is ignored.
- Ok holds its value while Ok_valid=1 and Ok_ready=0 (stable-under-stall guarantee).

Optional Feature:
- Macro: DEMUX4_CNT_EN.
- Defined:
  - CNT0..CNT3 ports exist.
  - CNTk increments by 1 on each drn_k and wraps modulo 2^CNT_WIDTH (2^CNT_WIDTH-1 -> 0).
  - RESET clears all counters to 0.
  - Counter updates are registered: visible the cycle after the drain.
- Undefined: CNT ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive RESET=1 for 2 cycles with I_valid=1 -> all Ok_valid=0, Ok=0, no word captured. After release, with all Ok_ready=1 -> I_ready=1.
- Single route: WIDTH=8, I=0xA5, S=2, I_valid=1 for 1 cycle, O2_ready=0 -> next cycle O2=0xA5, O2_valid=1, other valids 0. Hold O2_ready=0 for 5 cycles -> O2 stays 0xA5. Raise O2_ready -> O2_valid=0 one cycle later.
- Stall isolation: O1 full with O1_ready=0. Send S=1 -> I_ready=0, no change. Switch to S=3, I=0x3C -> I_ready=1 and O3=0x3C next cycle; O1 unchanged.
- Full-rate stream: O0_ready=1 continuously, S=0, I=0x01,0x02,...,0x10 on consecutive cycles -> I_ready=1 every cycle, O0 shows each value exactly 1 cycle later, O0_valid stays 1 through the burst.
- Simultaneous events: O2 full, O2_ready=1 and accept S=2, I=0x77 in the same cycle -> O2=0x77, O2_valid=1 next cycle, with no bubble and no lost word.
- Counter wrap (DEMUX4_CNT_EN, CNT_WIDTH=4): 17 drains on channel 0 -> CNT0=1, CNT1..CNT3=0. Assert RESET -> all counters 0.
